clk_run_ctl: RTL and testbench

CLK_RUN_CTL -- requirements
Module: clk_run_ctl

---
 rtl/clk_run_ctl.sv | 145 ++++++++++++++
 tb/tb_clk_run_ctl.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_run_ctl.sv
// -----------------------------------------------------------------------------
// clk_run_ctl
// Run/halt/step controller that produces a glitch-free clock enable for a
// downstream edge gate. Three asynchronous push-buttons are synchronized and
// edge-detected; a CPU halt request (already synchronous) can stop RUN/STEP.
//
// Parameters
//   SYNC_STAGES  synchronizer depth per button input (>= 2)
//   STEP_W       width of step_n and of the step burst counter
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   run_btn   in   async level, rising edge requests free-run
//   halt_btn  in   async level, rising edge requests halt
//   step_btn  in   async level, rising edge requests a step burst
//   step_n    in   cycles per step burst (0 behaves as 1)
//   halt_req  in   synchronous halt request from the CPU
//   en        out  registered clock enable
//   mode      out  current state: HALT=00, RUN=01, STEP=10
//   cycles    out  number of edges sampled with en=1, wraps at 2^16
// -----------------------------------------------------------------------------
module clk_run_ctl #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned STEP_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run_btn,
   input  logic              halt_btn,
   input  logic              step_btn,
   input  logic [STEP_W-1:0] step_n,
   input  logic              halt_req,
   output logic              en,
   output logic [1:0]        mode,
   output logic [15:0]       cycles
);

   localparam int unsigned NBTN     = 3;
   localparam int unsigned BTN_RUN  = 0;
   localparam int unsigned BTN_HALT = 1;
   localparam int unsigned BTN_STEP = 2;
   localparam int unsigned CYC_W    = 16;

   typedef enum logic [1:0] {
      S_HALT = 2'b00,
      S_RUN  = 2'b01,
      S_STEP = 2'b10
   } mode_t;

   logic [SYNC_STAGES-1:0][NBTN-1:0] r_sync;
   logic [NBTN-1:0]                  r_prev;
   logic [NBTN-1:0]                  r_rise;
   logic [NBTN-1:0]                  w_btn;
   logic [NBTN-1:0]                  w_sync_out;

   mode_t              r_mode;
   mode_t              w_next_mode;
   logic [STEP_W-1:0]  r_cnt;
   logic [STEP_W-1:0]  w_next_cnt;
   logic               r_en;
   logic [CYC_W-1:0]   r_cycles;
   logic               w_halt_any;

   assign w_btn      = {step_btn, halt_btn, run_btn};
   assign w_sync_out = r_sync[SYNC_STAGES-1];

   // Synchronizer chain plus edge detector; the rise pulse is registered so
   // the FSM sees a clean single-cycle request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
         r_prev <= '0;
         r_rise <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], w_btn};
         r_prev <= w_sync_out;
         r_rise <= w_sync_out & ~r_prev;
      end
   end

   // halt_req only matters outside HALT; the halt button always wins.
   assign w_halt_any = r_rise[BTN_HALT] | halt_req;

   // State, burst counter, enable and cycle counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode   <= S_HALT;
         r_cnt    <= '0;
         r_en     <= 1'b0;
         r_cycles <= '0;
      end else begin
         r_mode <= w_next_mode;
         r_cnt  <= w_next_cnt;
         r_en   <= (w_next_mode != S_HALT);
         if (r_en) begin
            r_cycles <= r_cycles + CYC_W'(1);
         end
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_mode = r_mode;
      w_next_cnt  = r_cnt;
      unique case (r_mode)
         S_HALT: begin
            if (r_rise[BTN_HALT]) begin
               w_next_mode = S_HALT;
            end else if (r_rise[BTN_RUN]) begin
               w_next_mode = S_RUN;
            end else if (r_rise[BTN_STEP]) begin
               w_next_mode = S_STEP;
               // Burst length is latched here; later step_n changes are ignored.
               w_next_cnt  = (step_n == '0) ? STEP_W'(1) : step_n;
            end
         end
         S_RUN: begin
            if (w_halt_any) begin
               w_next_mode = S_HALT;
            end
         end
         S_STEP: begin
            if (w_halt_any) begin
               w_next_mode = S_HALT;
               w_next_cnt  = '0;
            end else if (r_cnt == STEP_W'(1)) begin
               w_next_mode = S_HALT;
               w_next_cnt  = '0;
            end else begin
               w_next_cnt  = r_cnt - STEP_W'(1);
            end
         end
         default: begin
            w_next_mode = S_HALT;
            w_next_cnt  = '0;
         end
      endcase
   end

   assign en     = r_en;
   assign mode   = r_mode;
   assign cycles = r_cycles;

endmodule

// File: tb/tb_clk_run_ctl.sv
// -----------------------------------------------------------------------------
// tb_clk_run_ctl
// Self-checking bench for clk_run_ctl. A behavioural model tracks the sampled
// button history, the requested burst length and the enable count; each
// scenario task compares the DUT against the model and against fixed values.
// -----------------------------------------------------------------------------
module tb_clk_run_ctl;

   localparam int unsigned S = 2;
   localparam int unsigned W = 8;
   localparam logic [1:0] M_HALT = 2'b00;
   localparam logic [1:0] M_RUN  = 2'b01;
   localparam logic [1:0] M_STEP = 2'b10;

   logic         clk = 1'b0;
   logic         rst;
   logic         run_btn, halt_btn, step_btn, halt_req;
   logic [W-1:0] step_n;
   logic         en;
   logic [1:0]   mode;
   logic [15:0]  cycles;

   int n_cmp = 0;
   int n_bad = 0;

   clk_run_ctl #(.SYNC_STAGES(S), .STEP_W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .run_btn  (run_btn),
      .halt_btn (halt_btn),
      .step_btn (step_btn),
      .step_n   (step_n),
      .halt_req (halt_req),
      .en       (en),
      .mode     (mode),
      .cycles   (cycles)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // h_* bit j holds the button level sampled j+1 edges ago. A level sampled
   // at edge k acts at edge k+S+1, so the rise seen now is h[S] & ~h[S+1].
   logic [S+1:0] h_run, h_halt, h_step;
   logic [1:0]   m_mode;
   logic         m_en;
   logic [15:0]  m_cycles;
   int           m_left;
   logic         m_rr, m_hr, m_sr;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         h_run = '0; h_halt = '0; h_step = '0;
         m_mode = M_HALT; m_en = 1'b0; m_cycles = '0; m_left = 0;
      end else begin
         m_rr = h_run[S]  & ~h_run[S+1];
         m_hr = h_halt[S] & ~h_halt[S+1];
         m_sr = h_step[S] & ~h_step[S+1];
         h_run  = {h_run[S:0],  run_btn};
         h_halt = {h_halt[S:0], halt_btn};
         h_step = {h_step[S:0], step_btn};
         if (m_en) m_cycles = m_cycles + 16'd1;
         if (m_mode == M_HALT) begin
            if (!m_hr && m_rr) m_mode = M_RUN;
            else if (!m_hr && m_sr) begin
               m_mode = M_STEP;
               m_left = (step_n == 0) ? 1 : int'(step_n);
            end
         end else if (m_hr || halt_req) begin
            m_mode = M_HALT;
            m_left = 0;
         end else if (m_mode == M_STEP) begin
            // m_left counts remaining enabled cycles of the burst
            m_left = m_left - 1;
            if (m_left == 0) m_mode = M_HALT;
         end
         m_en = (m_mode != M_HALT);
      end
   end

   // ---------------- scenarios ----------------
   task automatic test_reset;
      rst = 1'b1;
      run_btn = 0; halt_btn = 0; step_btn = 0; halt_req = 0; step_n = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (mode !== M_HALT || en !== 1'b0 || cycles !== 16'd0) begin
         n_bad++;
         $display("FAIL reset: mode=%0d en=%0b cycles=%0d, expected 0 0 0", mode, en, cycles);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_run;
      logic [1:0] exp_m;
      run_btn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) run_btn = 1'b0;
         exp_m = (i >= 3) ? M_RUN : M_HALT;
         n_cmp++;
         if (mode !== exp_m || en !== (exp_m != M_HALT) || mode !== m_mode || cycles !== m_cycles) begin
            n_bad++;
            $display("FAIL run_start[%0d]: mode=%0d en=%0b cycles=%0d, expected mode=%0d cycles=%0d",
                     i, mode, en, cycles, exp_m, m_cycles);
         end
      end
      halt_btn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) halt_btn = 1'b0;
         exp_m = (i >= 3) ? M_HALT : M_RUN;
         n_cmp++;
         if (mode !== exp_m || en !== (exp_m != M_HALT) || cycles !== m_cycles) begin
            n_bad++;
            $display("FAIL run_halt[%0d]: mode=%0d en=%0b cycles=%0d, expected mode=%0d cycles=%0d",
                     i, mode, en, cycles, exp_m, m_cycles);
         end
      end
   endtask

   task automatic test_step(input logic [W-1:0] n);
      int          en_cnt = 0;
      logic [15:0] c0 = cycles;
      int          exp_len = (n == 0) ? 1 : int'(n);
      step_n   = n;
      step_btn = 1'b1;
      for (int i = 0; i < exp_len + 8; i++) begin
         @(negedge clk);
         if (i == 0) step_btn = 1'b0;
         if (en) en_cnt++;
         n_cmp++;
         if (mode !== m_mode || en !== m_en || cycles !== m_cycles) begin
            n_bad++;
            $display("FAIL step%0d_cycle[%0d]: mode=%0d en=%0b cycles=%0d, expected %0d %0b %0d",
                     n, i, mode, en, cycles, m_mode, m_en, m_cycles);
         end
      end
      n_cmp++;
      if (en_cnt != exp_len || cycles !== 16'(c0 + 16'(exp_len)) || mode !== M_HALT) begin
         n_bad++;
         $display("FAIL step%0d_burst: en_cycles=%0d delta=%0d mode=%0d, expected %0d %0d 0",
                  n, en_cnt, 16'(cycles - c0), mode, exp_len, exp_len);
      end
   endtask

   task automatic test_cpu_halt;
      run_btn = 1'b1;
      @(negedge clk);
      run_btn = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (mode !== M_RUN) begin
         n_bad++;
         $display("FAIL cpu_halt_pre: mode=%0d, expected 1", mode);
      end
      halt_req = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
      n_cmp++;
      if (mode !== M_HALT || en !== 1'b0 || cycles !== m_cycles) begin
         n_bad++;
         $display("FAIL cpu_halt_edge: mode=%0d en=%0b cycles=%0d, expected 0 0 %0d",
                  mode, en, cycles, m_cycles);
      end
      halt_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_cmp++;
         if (mode !== M_HALT || en !== 1'b0) begin
            n_bad++;
            $display("FAIL cpu_halt_idle[%0d]: mode=%0d en=%0b, expected 0 0", i, mode, en);
         end
      end
      // run rise with halt_req held: exactly one enabled cycle
      run_btn = 1'b1;
      begin
         int en_cnt = 0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) run_btn = 1'b0;
            if (en) en_cnt++;
         end
         n_cmp++;
         if (en_cnt != 1 || mode !== M_HALT) begin
            n_bad++;
            $display("FAIL run_with_halt_req: en_cycles=%0d mode=%0d, expected 1 0", en_cnt, mode);
         end
      end
      halt_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_interrupted_step;
      int          en_cnt = 0;
      int          wait_n = 0;
      logic [15:0] c0 = cycles;
      step_n   = 8'd200;
      step_btn = 1'b1;
      @(negedge clk);
      step_btn = 1'b0;
      while (!en && wait_n < 10) begin
         @(negedge clk);
         wait_n++;
      end
      n_cmp++;
      if (!en) begin
         n_bad++;
         $display("FAIL istep_start: en=%0b after %0d cycles, expected 1", en, wait_n);
      end
      while (en_cnt < 10) begin
         if (en) en_cnt++;
         if (en_cnt == 3) step_n = 8'd2;
         if (en_cnt < 10) @(negedge clk);
      end
      n_cmp++;
      if (mode !== M_STEP) begin
         n_bad++;
         $display("FAIL istep_step_n_change: mode=%0d, expected 2", mode);
      end
      halt_req = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
      n_cmp++;
      if (en !== 1'b0 || mode !== M_HALT || cycles !== 16'(c0 + 16'd10) || cycles !== m_cycles) begin
         n_bad++;
         $display("FAIL istep_halt: en=%0b mode=%0d delta=%0d, expected 0 0 10",
                  en, mode, 16'(cycles - c0));
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_priority;
      logic [1:0] exp_m;
      run_btn = 1'b1; step_btn = 1'b1; step_n = 8'd3;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) begin run_btn = 1'b0; step_btn = 1'b0; end
         exp_m = (i >= 3) ? M_RUN : M_HALT;
         n_cmp++;
         if (mode !== exp_m || mode !== m_mode) begin
            n_bad++;
            $display("FAIL run_step_same[%0d]: mode=%0d, expected %0d", i, mode, exp_m);
         end
      end
      // halt together with run in RUN, then halt with step in HALT
      halt_btn = 1'b1; run_btn = 1'b1;
      @(negedge clk);
      halt_btn = 1'b0; run_btn = 1'b0;
      repeat (5) @(negedge clk);
      halt_btn = 1'b1; step_btn = 1'b1;
      @(negedge clk);
      halt_btn = 1'b0; step_btn = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (mode !== M_HALT || en !== 1'b0 || cycles !== m_cycles) begin
         n_bad++;
         $display("FAIL halt_with_others: mode=%0d en=%0b cycles=%0d, expected 0 0 %0d",
                  mode, en, cycles, m_cycles);
      end
   endtask

   task automatic test_reset_mid_step;
      logic [1:0] exp_m;
      step_n = 8'd50; step_btn = 1'b1;
      @(negedge clk);
      step_btn = 1'b0;
      repeat (8) @(negedge clk);
      n_cmp++;
      if (en !== 1'b1 || mode !== M_STEP) begin
         n_bad++;
         $display("FAIL mid_step_pre: en=%0b mode=%0d, expected 1 2", en, mode);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      run_btn = 1'b1;
      #1;
      n_cmp++;
      if (en !== 1'b0 || cycles !== 16'd0 || mode !== M_HALT) begin
         n_bad++;
         $display("FAIL async_reset: en=%0b cycles=%0d mode=%0d, expected 0 0 0", en, cycles, mode);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         exp_m = (i >= 3) ? M_RUN : M_HALT;
         n_cmp++;
         if (mode !== exp_m || mode !== m_mode || cycles !== m_cycles) begin
            n_bad++;
            $display("FAIL held_after_reset[%0d]: mode=%0d cycles=%0d, expected %0d %0d",
                     i, mode, cycles, exp_m, m_cycles);
         end
      end
      halt_btn = 1'b1;
      @(negedge clk);
      halt_btn = 1'b0;
      repeat (12) @(negedge clk);
      n_cmp++;
      if (mode !== M_HALT || en !== 1'b0) begin
         n_bad++;
         $display("FAIL held_single_rise: mode=%0d en=%0b, expected 0 0", mode, en);
      end
      run_btn = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_random;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) run_btn  = ~run_btn;
         if ($urandom_range(0, 14) == 0) halt_btn = ~halt_btn;
         if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
         halt_req = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 3) == 0) step_n = W'($urandom_range(0, 12));
         @(negedge clk);
         n_cmp++;
         if (mode !== m_mode || en !== m_en || cycles !== m_cycles) begin
            n_bad++;
            $display("FAIL random[%0d]: mode=%0d en=%0b cycles=%0d, expected %0d %0b %0d",
                     i, mode, en, cycles, m_mode, m_en, m_cycles);
         end
      end
      run_btn = 0; halt_btn = 0; step_btn = 0; halt_req = 0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_wrap;
      logic [15:0] prev;
      bit          seen = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      run_btn = 1'b1;
      @(negedge clk);
      run_btn = 1'b0;
      prev = cycles;
      for (int i = 0; i < 65600 && !seen; i++) begin
         @(negedge clk);
         if (prev == 16'hFFFF) begin
            seen = 1'b1;
            n_cmp++;
            if (cycles !== 16'h0000 || cycles !== m_cycles) begin
               n_bad++;
               $display("FAIL cycles_wrap: cycles=%0h, expected 0", cycles);
            end
         end
         prev = cycles;
      end
      n_cmp++;
      if (!seen || mode !== M_RUN) begin
         n_bad++;
         $display("FAIL wrap_reached: seen=%0b mode=%0d, expected 1 1", seen, mode);
      end
   endtask

   initial begin
      test_reset();
      test_run();
      test_step(8'd5);
      test_step(8'd0);
      test_cpu_halt();
      test_interrupted_step();
      test_priority();
      test_reset_mid_step();
      test_random();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
